// File: rtl/sequencer_pkg.sv
// Shared definitions for the program sequencer.
//   seq_state_e          : FSM state encoding
//   HALT_INSTR_DEFAULT   : default instruction word that ends execution
//   CYCLE_W              : width of the cycle counter output
package sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;
  localparam int         CYCLE_W            = 16;

endpackage

// File: rtl/pc_register.sv
// Program counter register with increment/wrap and branch-target select.
// Ports:
//   clk, reset (async, active-high)
//   clear   : force pc to 0 (accepted start)
//   advance : retire the current instruction; pc <= branch ? target : pc+1
//   branch  : branch-taken flag for the retiring instruction
//   target  : branch target
//   pc      : current program counter
module pc_register
  #(parameter int PC_W = 10)
  (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  input  logic            branch,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
  );

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;

  // Natural PC_W-bit overflow gives the modulo-2^PC_W wrap.
  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else if (clear) begin
      pc_q <= '0;
    end else if (advance) begin
      pc_q <= branch ? target : pc_inc;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches, executes, waits on data memory and retires
// instructions until the halt word is seen.
// Ports:
//   clk, reset (async, active-high)
//   start               : begin execution at pc 0 (accepted in IDLE and DONE)
//   instr               : instruction word at pc, valid in EXEC
//   branch, lutTarget   : branch-taken flag and its target for instr
//   memRead, memWrite   : instr accesses data memory
//   memReady            : data memory has completed the access
//   pc, fetchEn         : instruction-memory address and read enable
//   commit              : single-cycle retire pulse
//   busy, done          : activity / finished status
//   cycleCount          : cycles from start to halt
// Build option: define SEQ_CYCLE_COUNT_EN to build the cycle counter;
// otherwise cycleCount is tied to 0.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start after reset
// FETCH   | instruction-memory read at pc (one cycle)
// EXEC    | decode: halt, stall on memory, or retire
// MEMWAIT | data access outstanding; retire when memReady rises
// DONE    | halt seen; done held high until the next start
module program_sequencer
  import sequencer_pkg::*;
  #(
  parameter int         PC_W       = 10,
  parameter logic [8:0] HALT_INSTR = HALT_INSTR_DEFAULT
  )
  (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         instr,
  input  logic               branch,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic               memReady,
  input  logic [PC_W-1:0]    lutTarget,
  output logic [PC_W-1:0]    pc,
  output logic               fetchEn,
  output logic               commit,
  output logic               busy,
  output logic               done,
  output logic [CYCLE_W-1:0] cycleCount
  );

  seq_state_e state;
  seq_state_e next_state;
  logic       start_accept;
  logic       is_halt;
  logic       mem_stall;

  assign is_halt   = (instr == HALT_INSTR);
  assign mem_stall = (memRead || memWrite) && !memReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   next_state = EXEC;
      EXEC: begin
        if (is_halt)        next_state = DONE;
        else if (mem_stall) next_state = MEMWAIT;
        else                next_state = FETCH;
      end
      MEMWAIT: if (memReady) next_state = FETCH;
      DONE:    if (start) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  // commit is decoded from the registered state, so an async reset drops it
  // in the same cycle and an aborted memory access never retires.
  always_comb begin
    fetchEn      = 1'b0;
    commit       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE:    start_accept = start;
      FETCH: begin
        fetchEn = 1'b1;
        busy    = 1'b1;
      end
      EXEC: begin
        busy   = 1'b1;
        commit = !is_halt && !mem_stall;
      end
      MEMWAIT: begin
        busy   = 1'b1;
        commit = memReady;
      end
      DONE: begin
        done         = 1'b1;
        start_accept = start;
      end
      default: ;
    endcase
  end

  pc_register #(.PC_W(PC_W)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_accept),
    .advance (commit),
    .branch  (branch),
    .target  (lutTarget),
    .pc      (pc)
  );

`ifdef SEQ_CYCLE_COUNT_EN
  logic [CYCLE_W-1:0] cycle_q;

  // Counts busy cycles; the edge that moves into DONE is not counted, so the
  // value shown while the halt word sits in EXEC is the one held in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
    end else if (start_accept) begin
      cycle_q <= '0;
    end else if (busy && (next_state != DONE) && (cycle_q != {CYCLE_W{1'b1}})) begin
      cycle_q <= cycle_q + {{(CYCLE_W-1){1'b0}}, 1'b1};
    end
  end

  assign cycleCount = cycle_q;
`else
  assign cycleCount = '0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  localparam int PC_W = 10;
`ifdef SEQ_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            start;
  logic [8:0]      instr;
  logic            branch;
  logic            memRead;
  logic            memWrite;
  logic            memReady;
  logic [PC_W-1:0] lutTarget;
  logic [PC_W-1:0] pc;
  logic            fetchEn;
  logic            commit;
  logic            busy;
  logic            done;
  logic [15:0]     cycleCount;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h010;

  program_sequencer #(.PC_W(PC_W), .HALT_INSTR(HALT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .instr      (instr),
    .branch     (branch),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memReady   (memReady),
    .lutTarget  (lutTarget),
    .pc         (pc),
    .fetchEn    (fetchEn),
    .commit     (commit),
    .busy       (busy),
    .done       (done),
    .cycleCount (cycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 2ns after the edge and
  // outputs sampled 1ns later, well clear of both clock edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (pc !== '0 || fetchEn !== 1'b0 || commit !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || cycleCount !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: pc=%h fetchEn=%b commit=%b busy=%b done=%b cnt=%0d, required all zero",
               pc, fetchEn, commit, busy, done, cycleCount);
    end
    tick();
    reset = 1'b0;
    tick();
    settle();
    n_checks++;
    if (busy !== 1'b0 || fetchEn !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: busy=%b fetchEn=%b, required 0 0", busy, fetchEn);
    end
  endtask

  // start, three plain instructions, then halt at pc 3
  task automatic test_linear();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if (pc !== PC_W'(k) || fetchEn !== 1'b1 || commit !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL linear_fetch%0d: pc=%h fetchEn=%b commit=%b busy=%b, required pc=%0d 1 0 1",
                 k, pc, fetchEn, commit, busy, k);
      end
      tick();
      instr = NOP;
      settle();
      n_checks++;
      if (commit !== 1'b1 || fetchEn !== 1'b0) begin
        n_fail++;
        $display("FAIL linear_exec%0d: commit=%b fetchEn=%b, required 1 0", k, commit, fetchEn);
      end
      tick();
    end
    settle();
    n_checks++;
    if (pc !== 10'd3 || fetchEn !== 1'b1) begin
      n_fail++;
      $display("FAIL linear_halt_fetch: pc=%h fetchEn=%b, required 003 1", pc, fetchEn);
    end
    tick();
    instr = HALT;
    settle();
    n_checks++;
    if (commit !== 1'b0) begin
      n_fail++;
      $display("FAIL linear_halt_commit: commit=%b, required 0", commit);
    end
    tick();
    settle();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== 10'd3 ||
        cycleCount !== (CNT_EN ? 16'd7 : 16'd0)) begin
      n_fail++;
      $display("FAIL linear_done: done=%b busy=%b pc=%h cnt=%0d, required 1 0 003 %0d",
               done, busy, pc, cycleCount, CNT_EN ? 7 : 0);
    end
    tick();
    settle();
    n_checks++;
    if (done !== 1'b1 || cycleCount !== (CNT_EN ? 16'd7 : 16'd0)) begin
      n_fail++;
      $display("FAIL linear_done_hold: done=%b cnt=%0d, required 1 %0d",
               done, cycleCount, CNT_EN ? 7 : 0);
    end
  endtask

  // start while busy is ignored; start in DONE restarts at pc 0
  task automatic test_start_while_busy();
    start = 1'b1;
    tick();
    settle();
    n_checks++;
    if (done !== 1'b0 || pc !== 10'd0 || busy !== 1'b1 || cycleCount !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_from_done: done=%b pc=%h busy=%b cnt=%0d, required 0 000 1 0",
               done, pc, busy, cycleCount);
    end
    tick();
    instr = NOP;
    tick();
    settle();
    n_checks++;
    if (pc !== 10'd1 || fetchEn !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: pc=%h fetchEn=%b, required 001 1", pc, fetchEn);
    end
    start = 1'b0;
    tick();
    instr = HALT;
    tick();
    settle();
    n_checks++;
    if (done !== 1'b1 || pc !== 10'd1 || cycleCount !== (CNT_EN ? 16'd3 : 16'd0)) begin
      n_fail++;
      $display("FAIL second_done: done=%b pc=%h cnt=%0d, required 1 001 %0d",
               done, pc, cycleCount, CNT_EN ? 3 : 0);
    end
    start = 1'b1;
    settle();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_before_edge: done=%b, required 1", done);
    end
    tick();
    start = 1'b0;
    settle();
    n_checks++;
    if (done !== 1'b0 || pc !== 10'd0 || fetchEn !== 1'b1) begin
      n_fail++;
      $display("FAIL done_falls: done=%b pc=%h fetchEn=%b, required 0 000 1", done, pc, fetchEn);
    end
  endtask

  // enters in FETCH at pc 0
  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      tick();
      instr = NOP;
      tick();
    end
    settle();
    n_checks++;
    if (pc !== 10'd2) begin
      n_fail++;
      $display("FAIL branch_pre_pc: pc=%h, required 002", pc);
    end
    tick();
    instr     = 9'h020;
    branch    = 1'b1;
    lutTarget = 10'h040;
    settle();
    n_checks++;
    if (commit !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_commit: commit=%b, required 1", commit);
    end
    tick();
    branch = 1'b0;
    settle();
    n_checks++;
    if (pc !== 10'h040 || commit !== 1'b0 || fetchEn !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_target: pc=%h commit=%b fetchEn=%b, required 040 0 1", pc, commit, fetchEn);
    end
  endtask

  // enters in FETCH at pc 0x040
  task automatic test_wrap();
    tick();
    instr     = NOP;
    branch    = 1'b1;
    lutTarget = 10'h3FF;
    tick();
    branch = 1'b0;
    settle();
    n_checks++;
    if (pc !== 10'h3FF) begin
      n_fail++;
      $display("FAIL wrap_pre_pc: pc=%h, required 3ff", pc);
    end
    tick();
    instr = NOP;
    tick();
    settle();
    n_checks++;
    if (pc !== 10'h000) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h, required 000", pc);
    end
  endtask

  // enters in FETCH at pc 0
  task automatic test_memwait();
    tick();
    instr    = 9'h030;
    memRead  = 1'b1;
    memReady = 1'b0;
    settle();
    n_checks++;
    if (commit !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_exec_stall: commit=%b, required 0", commit);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      settle();
      n_checks++;
      if (commit !== 1'b0 || busy !== 1'b1 || fetchEn !== 1'b0 || pc !== 10'd0) begin
        n_fail++;
        $display("FAIL memwait%0d: commit=%b busy=%b fetchEn=%b pc=%h, required 0 1 0 000",
                 k, commit, busy, fetchEn, pc);
      end
    end
    tick();
    memReady = 1'b1;
    settle();
    n_checks++;
    if (commit !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_ready_commit: commit=%b, required 1", commit);
    end
    tick();
    memRead  = 1'b0;
    memReady = 1'b0;
    settle();
    n_checks++;
    if (pc !== 10'd1 || commit !== 1'b0 || fetchEn !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_after: pc=%h commit=%b fetchEn=%b, required 001 0 1", pc, commit, fetchEn);
    end
    tick();
    memWrite = 1'b1;
    memReady = 1'b1;
    settle();
    n_checks++;
    if (commit !== 1'b1) begin
      n_fail++;
      $display("FAIL store_ready_commit: commit=%b, required 1", commit);
    end
    tick();
    memWrite = 1'b0;
    memReady = 1'b0;
    settle();
    n_checks++;
    if (pc !== 10'd2) begin
      n_fail++;
      $display("FAIL store_pc: pc=%h, required 002", pc);
    end
  endtask

  // enters in FETCH at pc 2
  task automatic test_reset_in_memwait();
    tick();
    instr    = 9'h030;
    memRead  = 1'b1;
    memReady = 1'b0;
    tick();
    settle();
    n_checks++;
    if (busy !== 1'b1 || commit !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_abort_memwait: busy=%b commit=%b, required 1 0", busy, commit);
    end
    reset    = 1'b1;
    memReady = 1'b1;
    settle();
    n_checks++;
    if (commit !== 1'b0 || pc !== 10'd0 || busy !== 1'b0 || done !== 1'b0 ||
        fetchEn !== 1'b0 || cycleCount !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_reset: commit=%b pc=%h busy=%b done=%b fetchEn=%b cnt=%0d, required 0 000 0 0 0 0",
               commit, pc, busy, done, fetchEn, cycleCount);
    end
    tick();
    reset    = 1'b0;
    memRead  = 1'b0;
    memReady = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    settle();
    n_checks++;
    if (pc !== 10'd0 || fetchEn !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_fetch: pc=%h fetchEn=%b, required 000 1", pc, fetchEn);
    end
    tick();
    instr = NOP;
    settle();
    n_checks++;
    if (commit !== 1'b1) begin
      n_fail++;
      $display("FAIL rerun_commit: commit=%b, required 1", commit);
    end
    tick();
    settle();
    n_checks++;
    if (pc !== 10'd1) begin
      n_fail++;
      $display("FAIL rerun_pc: pc=%h, required 001", pc);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    instr     = '0;
    branch    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memReady  = 1'b0;
    lutTarget = '0;

    test_reset();
    test_linear();
    test_start_while_busy();
    test_branch();
    test_wrap();
    test_memwait();
    test_reset_in_memwait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // A retire pulse must never span two consecutive cycles.
  logic commit_d;
  always @(posedge clk) begin
    if (commit && commit_d) begin
      n_checks++;
      n_fail++;
      $display("FAIL commit_back_to_back: commit=1 two cycles, required single-cycle pulse");
    end
    commit_d <= commit;
  end

endmodule
